// File: rtl/cursor_cmd_decoder.sv
// cursor_cmd_decoder
// Turns PS/2 set-2 scan-code bytes into one-cycle control strobes for the
// 6-bit cursor position counter and a character-write strobe for the text
// buffer. E0 (extended) and F0 (break) prefixes are tracked by a small FSM.
// The counter's present value is fed back so the cursor saturates at both
// line ends.
//
// Optional feature: define CURSOR_WRAP_EN to replace saturation with
// wrap-around. With a full-range MAX_POS the counter's own wrap is used.
// With a short range the wrap becomes a parallel load of 0 or MAX_POS.
// In that case a typed character at the right end is paired with a parallel
// strobe rather than an increase.

module cursor_cmd_decoder #(
    parameter int unsigned POS_W   = 6,
    parameter int unsigned MAX_POS = 63
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [7:0]       scan_code,
    input  logic             scan_valid,
    input  logic [POS_W-1:0] cursor_pos,
    output logic             increase,
    output logic             decrease,
    output logic             parallel,
    output logic [POS_W-1:0] load,
    output logic             cursor_clr,
    output logic             char_strobe,
    output logic [7:0]       char_code,
    output logic             shift_held,
    output logic             proto_err
);

    // Prefix bytes
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    // Base make codes with a dedicated action
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    // Extended make codes
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_HOME   = 8'h6C;
    localparam logic [7:0] SC_END    = 8'h69;

    localparam logic [POS_W-1:0] POS_ZERO = '0;
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(MAX_POS);
`ifdef CURSOR_WRAP_EN
    // A short range cannot rely on the counter's natural wrap.
    localparam logic [63:0] POS_FULL  = (64'(1) << POS_W) - 64'(1);
    localparam bit          WRAP_LOAD = (64'(MAX_POS) < POS_FULL);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t           r_state;
    logic             r_increase;
    logic             r_decrease;
    logic             r_parallel;
    logic [POS_W-1:0] r_load;
    logic             r_cursor_clr;
    logic             r_char_strobe;
    logic [7:0]       r_char_code;
    logic             r_shift_held;
    logic             r_proto_err;

    logic             w_is_prefix;
    logic             w_is_shift;
    logic             w_is_modifier;
    // Step-left action (Left, Backspace)
    logic             w_dn_dec;
    logic             w_dn_par;
    logic [POS_W-1:0] w_dn_load;
    // Step-right action (Right)
    logic             w_up_inc;
    logic             w_up_par;
    logic [POS_W-1:0] w_up_load;
    // Cursor advance after a typed character
    logic             w_ch_inc;
    logic             w_ch_par;
    logic [POS_W-1:0] w_ch_load;

    // Byte classification
    always_comb begin
        w_is_prefix   = (scan_code == SC_EXT) || (scan_code == SC_BRK);
        w_is_shift    = (scan_code == SC_LSHIFT) || (scan_code == SC_RSHIFT);
        w_is_modifier = (scan_code == SC_CTRL) || (scan_code == SC_ALT) ||
                        (scan_code == SC_CAPS);
    end

    // Movement decisions at the line ends: saturate, or wrap when enabled
    always_comb begin
        w_dn_dec  = 1'b0;
        w_dn_par  = 1'b0;
        w_dn_load = POS_ZERO;
        w_up_inc  = 1'b0;
        w_up_par  = 1'b0;
        w_up_load = POS_ZERO;
        w_ch_inc  = 1'b0;
        w_ch_par  = 1'b0;
        w_ch_load = POS_ZERO;
`ifdef CURSOR_WRAP_EN
        if (cursor_pos == POS_ZERO && WRAP_LOAD) begin
            w_dn_par  = 1'b1;
            w_dn_load = POS_MAX;
        end else begin
            w_dn_dec  = 1'b1;
        end
        if (cursor_pos >= POS_MAX && WRAP_LOAD) begin
            w_up_par  = 1'b1;
            w_ch_par  = 1'b1;
        end else begin
            w_up_inc  = 1'b1;
            w_ch_inc  = 1'b1;
        end
`else
        w_dn_dec = (cursor_pos != POS_ZERO);
        w_up_inc = (cursor_pos != POS_MAX);
        w_ch_inc = (cursor_pos < POS_MAX);
`endif
    end

    // Prefix-tracking FSM with registered, single-cycle strobes
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state       <= S_IDLE;
            r_increase    <= 1'b0;
            r_decrease    <= 1'b0;
            r_parallel    <= 1'b0;
            r_load        <= POS_ZERO;
            r_cursor_clr  <= 1'b0;
            r_char_strobe <= 1'b0;
            r_char_code   <= 8'h00;
            r_shift_held  <= 1'b0;
            r_proto_err   <= 1'b0;
        end else begin
            r_increase    <= 1'b0;
            r_decrease    <= 1'b0;
            r_parallel    <= 1'b0;
            r_cursor_clr  <= 1'b0;
            r_char_strobe <= 1'b0;
            r_proto_err   <= 1'b0;

            if (scan_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (scan_code == SC_EXT) begin
                            r_state <= S_EXT;
                        end else if (scan_code == SC_BRK) begin
                            r_state <= S_BRK;
                        end else if (scan_code == SC_BKSP) begin
                            r_decrease <= w_dn_dec;
                            r_parallel <= w_dn_par;
                            if (w_dn_par) r_load <= w_dn_load;
                        end else if (scan_code == SC_ESC) begin
                            r_cursor_clr <= 1'b1;
                        end else if (scan_code == SC_ENTER) begin
                            r_parallel <= 1'b1;
                            r_load     <= POS_ZERO;
                        end else if (w_is_shift) begin
                            r_shift_held <= 1'b1;
                        end else if (!w_is_modifier) begin
                            r_char_strobe <= 1'b1;
                            r_char_code   <= scan_code;
                            r_increase    <= w_ch_inc;
                            r_parallel    <= w_ch_par;
                            if (w_ch_par) r_load <= w_ch_load;
                        end
                    end

                    S_EXT: begin
                        r_state <= S_IDLE;
                        if (scan_code == SC_BRK) begin
                            r_state <= S_EXT_BRK;
                        end else if (scan_code == SC_EXT) begin
                            r_proto_err <= 1'b1;
                        end else if (scan_code == SC_LEFT) begin
                            r_decrease <= w_dn_dec;
                            r_parallel <= w_dn_par;
                            if (w_dn_par) r_load <= w_dn_load;
                        end else if (scan_code == SC_RIGHT) begin
                            r_increase <= w_up_inc;
                            r_parallel <= w_up_par;
                            if (w_up_par) r_load <= w_up_load;
                        end else if (scan_code == SC_HOME) begin
                            r_parallel <= 1'b1;
                            r_load     <= POS_ZERO;
                        end else if (scan_code == SC_END) begin
                            r_parallel <= 1'b1;
                            r_load     <= POS_MAX;
                        end
                    end

                    S_BRK: begin
                        r_state <= S_IDLE;
                        if (w_is_prefix) begin
                            r_proto_err <= 1'b1;
                        end else if (w_is_shift) begin
                            r_shift_held <= 1'b0;
                        end
                    end

                    S_EXT_BRK: begin
                        // Extended releases carry no action.
                        r_state <= S_IDLE;
                        if (w_is_prefix) begin
                            r_proto_err <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign increase    = r_increase;
    assign decrease    = r_decrease;
    assign parallel    = r_parallel;
    assign load        = r_load;
    assign cursor_clr  = r_cursor_clr;
    assign char_strobe = r_char_strobe;
    assign char_code   = r_char_code;
    assign shift_held  = r_shift_held;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_cursor_cmd_decoder.sv
// Bench for cursor_cmd_decoder: directed scenarios plus random byte streams,
// every cycle compared against a prefix-aware behavioural key model.
`timescale 1ns/1ps

module tb_cursor_cmd_decoder;

    localparam int unsigned POS_W   = 6;
    localparam int unsigned MAX_POS = 63;

    logic             CLK = 1'b0;
    logic             CLR = 1'b0;
    logic [7:0]       scan_code = 8'h00;
    logic             scan_valid = 1'b0;
    logic [POS_W-1:0] cursor_pos = '0;
    logic             increase, decrease, parallel, cursor_clr;
    logic             char_strobe, shift_held, proto_err;
    logic [POS_W-1:0] load;
    logic [7:0]       char_code;

    int n_vec = 0;
    int n_bad = 0;

    // Model: which prefixes are pending, plus the expected outputs
    bit               m_e0, m_f0;
    logic             e_inc, e_dec, e_par, e_clr, e_cs, e_sh, e_err;
    logic [POS_W-1:0] e_load;
    logic [7:0]       e_cc;

    cursor_cmd_decoder #(.POS_W(POS_W), .MAX_POS(MAX_POS)) dut (
        .CLK(CLK), .CLR(CLR), .scan_code(scan_code), .scan_valid(scan_valid),
        .cursor_pos(cursor_pos), .increase(increase), .decrease(decrease),
        .parallel(parallel), .load(load), .cursor_clr(cursor_clr),
        .char_strobe(char_strobe), .char_code(char_code),
        .shift_held(shift_held), .proto_err(proto_err)
    );

    always #5 CLK = ~CLK;

    task automatic clear_pulses();
        e_inc = 0; e_dec = 0; e_par = 0; e_clr = 0; e_cs = 0; e_err = 0;
    endtask

    task automatic model_reset();
        clear_pulses();
        m_e0 = 0; m_f0 = 0; e_sh = 0; e_load = '0; e_cc = 8'h00;
    endtask

    // Apply one scan byte at cursor position p to the key model
    task automatic model_byte(input logic [7:0] b, input logic [POS_W-1:0] p);
        int pi;
        pi = int'(p);
        clear_pulses();
        if (b == 8'hE0) begin
            if (!m_e0 && !m_f0) m_e0 = 1;
            else begin e_err = 1; m_e0 = 0; m_f0 = 0; end
        end else if (b == 8'hF0) begin
            if (!m_f0) m_f0 = 1;
            else begin e_err = 1; m_e0 = 0; m_f0 = 0; end
        end else begin
            if (!m_e0 && !m_f0) begin
                case (b)
`ifdef CURSOR_WRAP_EN
                    8'h66: e_dec = 1;
`else
                    8'h66: e_dec = (pi != 0);
`endif
                    8'h76: e_clr = 1;
                    8'h5A: begin e_par = 1; e_load = '0; end
                    8'h12, 8'h59: e_sh = 1;
                    8'h14, 8'h11, 8'h58: ;
                    default: begin
                        e_cs = 1; e_cc = b;
`ifdef CURSOR_WRAP_EN
                        e_inc = 1;
`else
                        e_inc = (pi < int'(MAX_POS));
`endif
                    end
                endcase
            end else if (m_e0 && !m_f0) begin
                case (b)
`ifdef CURSOR_WRAP_EN
                    8'h6B: e_dec = 1;
                    8'h74: e_inc = 1;
`else
                    8'h6B: e_dec = (pi != 0);
                    8'h74: e_inc = (pi != int'(MAX_POS));
`endif
                    8'h6C: begin e_par = 1; e_load = '0; end
                    8'h69: begin e_par = 1; e_load = POS_W'(MAX_POS); end
                    default: ;
                endcase
            end else if (!m_e0 && m_f0) begin
                if (b == 8'h12 || b == 8'h59) e_sh = 0;
            end
            m_e0 = 0; m_f0 = 0;
        end
    endtask

    // One cycle: drive on the falling edge, model at the rising edge, compare 1ns later
    task automatic step(input logic v, input logic [7:0] b,
                        input logic [POS_W-1:0] p, input logic c);
        logic [22:0] act, exp_v;
        @(negedge CLK);
        scan_valid = v; scan_code = b; cursor_pos = p; CLR = c;
        @(posedge CLK);
        if (c) model_reset();
        else if (v) model_byte(b, p);
        else clear_pulses();
        #1;
        act   = {increase, decrease, parallel, load, cursor_clr, char_strobe,
                 char_code, shift_held, proto_err};
        exp_v = {e_inc, e_dec, e_par, e_load, e_clr, e_cs, e_cc, e_sh, e_err};
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL outputs t=%0t byte=%h v=%b pos=%0d clr=%b got inc/dec/par/load/clr/cs/cc/sh/err=%b/%b/%b/%0d/%b/%b/%h/%b/%b want %b/%b/%b/%0d/%b/%b/%h/%b/%b",
                     $time, b, v, p, c, increase, decrease, parallel, load,
                     cursor_clr, char_strobe, char_code, shift_held, proto_err,
                     e_inc, e_dec, e_par, e_load, e_clr, e_cs, e_cc, e_sh, e_err);
        end
    endtask

    task automatic key(input logic [7:0] b, input logic [POS_W-1:0] p);
        step(1'b1, b, p, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, '0, 1'b0);
    endtask

    // Hand-computed expectations that pin the model itself
    task automatic pin(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 15))
            0: return 8'hE0;   1: return 8'hF0;   2: return 8'h66;
            3: return 8'h76;   4: return 8'h5A;   5: return 8'h12;
            6: return 8'h59;   7: return 8'h6B;   8: return 8'h74;
            9: return 8'h6C;  10: return 8'h69;  11: return 8'h14;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic logic [POS_W-1:0] pick_pos();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return POS_W'(MAX_POS);
            2: return POS_W'(MAX_POS - 1);
            3: return POS_W'(1);
            default: return POS_W'($urandom_range(0, MAX_POS));
        endcase
    endfunction

    initial begin
        model_reset();
        step(1'b0, 8'h00, '0, 1'b1);
        step(1'b1, 8'h1C, '0, 1'b1);
        pin("reset_char_code", int'(char_code), 0);
        pin("reset_shift", int'(shift_held), 0);

        // Extended Right advances the cursor one cycle after the byte
        key(8'hE0, 6'd5);
        key(8'h74, 6'd5);
        pin("ext_right_inc", int'(increase), 1);
        idle();
        pin("inc_one_cycle", int'(increase), 0);

        // Character at the right end is written without moving; Backspace at 0 is inert
        key(8'h1C, 6'd63);
        pin("char_at_max_strobe", int'(char_strobe), 1);
        pin("char_at_max_no_inc", int'(increase), 0);
        key(8'h66, 6'd0);
        pin("bksp_at_zero", int'(decrease), 0);

        // Shift held across a character, released by its break
        key(8'h12, 6'd10);
        pin("shift_down", int'(shift_held), 1);
        key(8'h1C, 6'd10);
        key(8'hF0, 6'd11);
        key(8'h12, 6'd11);
        pin("shift_up", int'(shift_held), 0);
        key(8'h1C, 6'd11);
        pin("char_code_1c", int'(char_code), 8'h1C);

        // End, Home, then an extended release that must do nothing
        key(8'hE0, 6'd7);
        key(8'h69, 6'd7);
        pin("end_load", int'(load), 63);
        key(8'hE0, 6'd63);
        key(8'h6C, 6'd63);
        pin("home_par", int'(parallel), 1);
        key(8'hE0, 6'd9);
        key(8'hF0, 6'd9);
        key(8'h6B, 6'd9);
        pin("ext_break_quiet", int'(decrease), 0);

        // Double E0 is a protocol error; reset drops a half-received sequence
        key(8'hE0, 6'd9);
        key(8'hE0, 6'd9);
        pin("double_e0_err", int'(proto_err), 1);
        key(8'hE0, 6'd9);
        step(1'b1, 8'h6B, 6'd9, 1'b1);
        pin("clr_drops_left", int'(decrease), 0);
        key(8'h76, 6'd9);
        pin("esc_clr", int'(cursor_clr), 1);

        // Back-to-back characters
        key(8'h1C, 6'd10);
        key(8'h1C, 6'd10);
        key(8'h1C, 6'd10);
        pin("third_char_inc", int'(increase & char_strobe), 1);
        idle();

        // Random streams, including back-to-back bytes and sporadic resets
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 3) != 0), pick_byte(), pick_pos(),
                 ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
